// File: rtl/rob_pkg.sv
// Shared definitions for the speculative temporary file, dispatch tail and commit unit:
// entry field layout, instruction type codes and the commit FSM state type.
package rob_pkg;

  localparam int ENTRY_W = 73;

  localparam int RD_HI   = 72;
  localparam int RD_LO   = 68;
  localparam int PC_HI   = 67;
  localparam int PC_LO   = 36;
  localparam int TYPE_HI = 35;
  localparam int TYPE_LO = 34;
  localparam int DATA_HI = 33;
  localparam int DATA_LO = 2;
  localparam int SV_BIT  = 1;
  localparam int V_BIT   = 0;

  localparam logic [1:0] T_ALU    = 2'b00;
  localparam logic [1:0] T_LOAD   = 2'b01;
  localparam logic [1:0] T_STORE  = 2'b10;
  localparam logic [1:0] T_BRANCH = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_e;

  typedef logic [ENTRY_W-1:0] rob_entry_t;

  function automatic logic writes_rd(input logic [1:0] entry_type);
    return (entry_type == T_ALU) || (entry_type == T_LOAD);
  endfunction

endpackage

// File: rtl/rob_commit_unit_if.sv
// Bundle between the commit unit and its neighbours: dispatch pulse, head read port,
// retirement strobes, flush/redirect and debug visibility of the commit FSM.
interface rob_commit_unit_if #(
  parameter int PTR_W = 5
);
  import rob_pkg::*;

  // Handshakes: dispatch_new is a valid-only push with no ready, so the producer must
  // honour rob_full. Retirement treats head valid & spec_valid as valid and
  // !commit_stall as ready; an entry retires on a cycle where both hold (and count != 0).
  logic             dispatch_new;
  logic [PTR_W-1:0] tmp_rd_addr;
  rob_entry_t       tmp_rd_data;
  logic             commit_stall;
  logic             rob_full;
  logic             rob_empty;
  logic             arf_we;
  logic [4:0]       arf_waddr;
  logic [31:0]      arf_wdata;
  logic             store_commit;
  logic [31:0]      store_pc;
  logic             flush_out;
  logic [31:0]      redirect_pc;
  logic             overflow_err;
  rob_state_e       dbg_state;
  logic [PTR_W:0]   dbg_count;

  modport master (
    input  dispatch_new, tmp_rd_data, commit_stall,
    output tmp_rd_addr, rob_full, rob_empty, arf_we, arf_waddr, arf_wdata,
           store_commit, store_pc, flush_out, redirect_pc, overflow_err,
           dbg_state, dbg_count
  );

  modport slave (
    output dispatch_new, tmp_rd_data, commit_stall,
    input  tmp_rd_addr, rob_full, rob_empty, arf_we, arf_waddr, arf_wdata,
           store_commit, store_pc, flush_out, redirect_pc, overflow_err,
           dbg_state, dbg_count
  );

endinterface

// File: rtl/rob_occupancy.sv
// Head pointer and occupancy counter of the temporary file, with full/empty flags
// and a sticky error for allocation attempts while full.
module rob_occupancy #(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A push that coincides with a pop is accepted even when full: the slot frees this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (clear) begin
      head  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop && full) begin
        overflow_err <= 1'b1;
      end
      if (push && !pop && !full) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement from the temporary register file: one entry per cycle to the ARF,
// store path or branch check, with a pipeline-wide flush and redirect on mispredict.
module rob_commit_unit
  import rob_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int PTR_W        = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input logic               clock,
  input logic               reset,
  rob_commit_unit_if.master bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);

  rob_state_e       state;
  rob_state_e       state_next;
  logic [FC_W-1:0]  flush_cnt;
  logic             retire_en;
  logic             flush_active;

  logic [PTR_W-1:0] head;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow_err;

  logic [4:0]       e_rd;
  logic [31:0]      e_pc;
  logic [1:0]       e_type;
  logic [31:0]      e_data;
  logic             e_sv;
  logic             e_v;
  logic             retire;
  logic             mispredict;

  assign e_rd   = bus.tmp_rd_data[RD_HI:RD_LO];
  assign e_pc   = bus.tmp_rd_data[PC_HI:PC_LO];
  assign e_type = bus.tmp_rd_data[TYPE_HI:TYPE_LO];
  assign e_data = bus.tmp_rd_data[DATA_HI:DATA_LO];
  assign e_sv   = bus.tmp_rd_data[SV_BIT];
  assign e_v    = bus.tmp_rd_data[V_BIT];

  assign retire     = retire_en && !empty && e_v && e_sv && !bus.commit_stall;
  // Static not-taken prediction: anything other than the fall-through PC is a mispredict.
  assign mispredict = retire && (e_type == T_BRANCH) && (e_data != e_pc + 32'd4);

  rob_occupancy #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_occupancy (
    .clock        (clock),
    .reset        (reset),
    .clear        (mispredict),
    .push         (bus.dispatch_new && retire_en),
    .pop          (retire),
    .head         (head),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (mispredict) state_next = FLUSH;
      FLUSH:   if (flush_cnt == FC_LAST) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    retire_en    = 1'b0;
    flush_active = 1'b0;
    case (state)
      RUN:     retire_en = 1'b1;
      FLUSH:   flush_active = 1'b1;
      default: retire_en = 1'b0;
    endcase
  end

  // Commit strobes are one-cycle pulses; their data fields read zero when the strobe is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.arf_we       <= 1'b0;
      bus.arf_waddr    <= '0;
      bus.arf_wdata    <= '0;
      bus.store_commit <= 1'b0;
      bus.store_pc     <= '0;
      bus.redirect_pc  <= '0;
    end else begin
      bus.arf_we       <= retire && writes_rd(e_type) && (e_rd != 5'd0);
      bus.arf_waddr    <= (retire && writes_rd(e_type) && (e_rd != 5'd0)) ? e_rd : 5'd0;
      bus.arf_wdata    <= (retire && writes_rd(e_type) && (e_rd != 5'd0)) ? e_data : 32'd0;
      bus.store_commit <= retire && (e_type == T_STORE);
      bus.store_pc     <= (retire && (e_type == T_STORE)) ? e_pc : 32'd0;
      if (mispredict) begin
        bus.redirect_pc <= e_data;
      end
    end
  end

  assign bus.tmp_rd_addr  = head;
  assign bus.rob_full     = full;
  assign bus.rob_empty    = empty;
  assign bus.flush_out    = flush_active;
  assign bus.overflow_err = overflow_err;
  assign bus.dbg_state    = state;
  assign bus.dbg_count    = count;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios plus random traffic, with a retirement
// scoreboard fed at dispatch time and drained by an output monitor.
module tb_rob_commit_unit;
  import rob_pkg::*;

  localparam int DEPTH        = 32;
  localparam int PTR_W        = 5;
  localparam int FLUSH_CYCLES = 1;
  localparam int EW           = 39;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rob_commit_unit_if #(.PTR_W(PTR_W)) bus();

  rob_commit_unit #(
    .DEPTH        (DEPTH),
    .PTR_W        (PTR_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Temporary register file model: written one step after the dispatch edge, read combinationally.
  rob_entry_t tmp_file [DEPTH];
  always_comb bus.tmp_rd_data = tmp_file[bus.tmp_rd_addr];

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int flush_seen = 0;
  int tail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic rob_entry_t mk(input logic [4:0] rd, input logic [31:0] pc,
                                    input logic [1:0] t, input logic [31:0] d, input logic sv);
    rob_entry_t e;
    e = '0;
    e[RD_HI:RD_LO]     = rd;
    e[PC_HI:PC_LO]     = pc;
    e[TYPE_HI:TYPE_LO] = t;
    e[DATA_HI:DATA_LO] = d;
    e[SV_BIT]          = sv;
    e[V_BIT]           = 1'b1;
    return e;
  endfunction

  // Reference rules: what each retiring entry must show on the outputs.
  // Event word = {kind, reg, value}; kind 1 = ARF write, 2 = store, 3 = flush/redirect.
  function automatic int expect_of(input rob_entry_t e, output logic [EW-1:0] w);
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] d;
    rd = e[RD_HI:RD_LO];
    pc = e[PC_HI:PC_LO];
    d  = e[DATA_HI:DATA_LO];
    w  = '0;
    case (e[TYPE_HI:TYPE_LO])
      2'b00, 2'b01: begin
        if (rd == 5'd0) return 0;
        w = {2'd1, rd, d};
        return 1;
      end
      2'b10: begin
        w = {2'd2, 5'd0, pc};
        return 2;
      end
      default: begin
        if (d == pc + 32'd4) return 0;
        w = {2'd3, 5'd0, d};
        return 3;
      end
    endcase
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input rob_entry_t e);
    logic [EW-1:0] w;
    bus.dispatch_new = 1'b1;
    cyc();
    tmp_file[tail] = e;
    tail = (tail + 1) % DEPTH;
    bus.dispatch_new = 1'b0;
    if (expect_of(e, w) != 0) exp_q.push_back(w);
  endtask

  task automatic clear_file();
    for (int i = 0; i < DEPTH; i++) tmp_file[i] = '0;
    tail = 0;
  endtask

  task automatic complete_some(input int chance);
    for (int i = 0; i < DEPTH; i++) begin
      if (tmp_file[i][V_BIT] && !tmp_file[i][SV_BIT] && $urandom_range(0, chance - 1) == 0)
        tmp_file[i][SV_BIT] = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.rob_empty && exp_q.size() == 0 && !bus.flush_out) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    check(name, ok, 1);
  endtask

  function automatic rob_entry_t rand_entry();
    logic [1:0]  t;
    logic [31:0] pc;
    logic [31:0] d;
    t  = 2'($urandom_range(0, 3));
    pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    d  = $urandom();
    if (t == 2'b11) begin
      if ($urandom_range(0, 3) != 0) d = pc + 32'd4;
      else d = pc + 32'd8 + ($urandom_range(0, 255) << 2);
    end
    return mk(5'($urandom_range(0, 31)), pc, t, d, 1'($urandom_range(0, 1)));
  endfunction

  // Monitor: every commit strobe must match the oldest expected event.
  initial begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp_w;
    forever begin
      @(negedge clock);
      if (!reset && (bus.arf_we || bus.store_commit || bus.flush_out)) begin
        if (bus.arf_we) act = {2'd1, bus.arf_waddr, bus.arf_wdata};
        else if (bus.store_commit) act = {2'd2, 5'd0, bus.store_pc};
        else begin
          act = {2'd3, 5'd0, bus.redirect_pc};
          flush_seen++;
        end
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL commit_event: got %0h want none", act);
        end else begin
          exp_w = exp_q.pop_front();
          check("commit_event", act, exp_w);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    bit wrap_seen;
    bit flush_pending;
    logic [PTR_W-1:0] prev;
    rob_entry_t e;
    logic [EW-1:0] w;
    int idx;

    reset = 1'b1;
    bus.dispatch_new = 1'b0;
    bus.commit_stall = 1'b0;
    clear_file();
    repeat (3) @(posedge clock);
    #1;
    check("reset_flags", {bus.rob_empty, bus.rob_full, bus.tmp_rd_addr, bus.arf_we,
                          bus.store_commit, bus.flush_out, bus.overflow_err}, 11'b1_0_00000_0000);
    check("reset_data", {bus.arf_wdata, bus.store_pc}, 64'd0);
    check("reset_redirect", {bus.redirect_pc, bus.arf_waddr}, 37'd0);
    reset = 1'b0;
    cyc();

    // Three ALU entries; rd 0 retires silently.
    dispatch(mk(5'd5, 32'h1000, 2'b00, 32'h11, 1'b1));
    dispatch(mk(5'd6, 32'h1004, 2'b00, 32'h22, 1'b1));
    dispatch(mk(5'd0, 32'h1008, 2'b00, 32'h33, 1'b1));
    wait_drain("alu_drain", 20);
    check("alu_head", bus.tmp_rd_addr, 3);
    check("alu_empty", bus.rob_empty, 1);

    // Operand not ready for four cycles, then released.
    idx = tail;
    dispatch(mk(5'd7, 32'h2000, 2'b01, 32'h77, 1'b0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("sv_wait_quiet", bus.arf_we, 0);
      cyc();
    end
    tmp_file[idx][SV_BIT] = 1'b1;
    @(negedge clock);
    check("sv_release_early", bus.arf_we, 0);
    cyc();
    @(negedge clock);
    check("sv_release_write", bus.arf_we, 1);
    cyc();

    // Two cycles of commit_stall push retirement back by two cycles.
    bus.commit_stall = 1'b1;
    dispatch(mk(5'd8, 32'h2004, 2'b00, 32'h88, 1'b1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("stall_quiet", bus.arf_we, 0);
      cyc();
    end
    bus.commit_stall = 1'b0;
    @(negedge clock);
    check("stall_release_early", bus.arf_we, 0);
    cyc();
    @(negedge clock);
    check("stall_release_write", bus.arf_we, 1);
    cyc();
    wait_drain("stall_drain", 20);

    // Correct branch retires silently; mispredict flushes for one cycle.
    dispatch(mk(5'd0, 32'h100, 2'b11, 32'h104, 1'b1));
    dispatch(mk(5'd0, 32'h200, 2'b11, 32'h400, 1'b1));
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.flush_out) begin
        found = 1'b1;
        check("flush_state", bus.dbg_state, FLUSH);
        bus.dispatch_new = 1'b1;
        cyc();
        bus.dispatch_new = 1'b0;
        break;
      end
      cyc();
    end
    check("flush_seen", found, 1);
    @(negedge clock);
    check("flush_one_cycle", bus.flush_out, 0);
    check("flush_head", bus.tmp_rd_addr, 0);
    check("flush_count", bus.dbg_count, 0);
    check("flush_empty", bus.rob_empty, 1);
    check("flush_consumed", exp_q.size(), 0);
    cyc();
    clear_file();

    // Fill to full, dispatch+retire at full, then overflow.
    bus.commit_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      dispatch(mk(5'((i % 31) + 1), 32'h3000 + 32'(i * 4), (i % 2 == 1) ? 2'b01 : 2'b00,
                  $urandom(), 1'b1));
    @(negedge clock);
    check("fill_full", {bus.rob_full, bus.rob_empty, bus.overflow_err}, 3'b100);
    check("fill_count", bus.dbg_count, DEPTH);
    cyc();
    bus.commit_stall = 1'b0;
    dispatch(mk(5'd0, 32'h80, 2'b10, 32'h5555, 1'b1));
    bus.commit_stall = 1'b1;
    @(negedge clock);
    check("full_swap_flags", {bus.rob_full, bus.overflow_err}, 2'b10);
    check("full_swap_count", bus.dbg_count, DEPTH);
    check("full_swap_head", bus.tmp_rd_addr, 1);
    cyc();
    bus.dispatch_new = 1'b1;
    cyc();
    bus.dispatch_new = 1'b0;
    @(negedge clock);
    check("overflow_err", bus.overflow_err, 1);
    check("overflow_count", bus.dbg_count, DEPTH);
    cyc();

    // Drain through index 31; head wraps and the store sitting at index 0 retires last.
    bus.commit_stall = 1'b0;
    prev = bus.tmp_rd_addr;
    wrap_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.rob_empty && exp_q.size() == 0) break;
      cyc();
      if (prev == 5'd31 && bus.tmp_rd_addr != 5'd31) begin
        wrap_seen = 1'b1;
        check("head_wrap", bus.tmp_rd_addr, 0);
      end
      prev = bus.tmp_rd_addr;
    end
    check("head_wrap_seen", wrap_seen, 1);
    check("wrap_drained", {bus.rob_empty, 1'(exp_q.size() == 0)}, 2'b11);
    check("wrap_head", bus.tmp_rd_addr, tail);

    // Reset while flushing.
    dispatch(mk(5'd0, 32'h500, 2'b11, 32'h900, 1'b1));
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.flush_out) begin
        found = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_flush_flags", {bus.flush_out, bus.rob_empty, bus.arf_we, bus.store_commit,
                                  bus.overflow_err}, 5'b01000);
        check("rst_flush_ptrs", {bus.tmp_rd_addr, bus.dbg_count}, 0);
        check("rst_flush_redirect", bus.redirect_pc, 0);
        exp_q.delete();
        break;
      end
      cyc();
    end
    check("rst_flush_seen", found, 1);
    cyc();
    reset = 1'b0;
    clear_file();
    dispatch(mk(5'd9, 32'h600, 2'b00, 32'h99, 1'b1));
    wait_drain("post_reset_drain", 20);
    check("post_reset_head", bus.tmp_rd_addr, 1);

    // Random traffic with random operand readiness and downstream stalls.
    clear_file();
    bus.dispatch_new = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    flush_pending = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (bus.flush_out) begin
        clear_file();
        flush_pending = 1'b0;
      end
      bus.commit_stall = ($urandom_range(0, 3) == 0);
      complete_some(3);
      if (!flush_pending && !bus.flush_out && !bus.rob_full && $urandom_range(0, 1) == 1) begin
        e = rand_entry();
        if (expect_of(e, w) == 3) flush_pending = 1'b1;
        dispatch(e);
      end else begin
        cyc();
      end
    end
    bus.commit_stall = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.flush_out) begin
        clear_file();
        flush_pending = 1'b0;
      end
      complete_some(1);
      if (bus.rob_empty && exp_q.size() == 0 && !flush_pending && !bus.flush_out) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("random_drain", found, 1);
    check("random_head", bus.tmp_rd_addr, tail);
    check("random_no_overflow", bus.overflow_err, 0);

    repeat (3) cyc();
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
